// File: rtl/led_pwm_scanner.sv
// Row-scanning two-colour LED matrix driver with per-pixel PWM and a
// double-buffered frame. Optional blanking interval: LED_SCAN_BLANK_EN.
module led_pwm_scanner #(
   parameter int ROWS    = 16,
   parameter int COLS    = 16,
   parameter int BPP     = 2,
   parameter int FREQDIV = 0
) (
   input  logic                        CLK,
   input  logic                        RST,
   input  logic                        EnableCount,
   input  logic [ROWS*COLS*BPP-1:0]    RedLevels,
   input  logic [ROWS*COLS*BPP-1:0]    GrnLevels,
   input  logic                        FrameValid,
   output logic                        FrameAck,
   output logic                        FrameStart,
   output logic [$clog2(ROWS)-1:0]     RowSelect,
   output logic [COLS-1:0]             RedCols,
   output logic [COLS-1:0]             GrnCols,
   output logic                        Blank
);

   localparam int N  = ROWS*COLS*BPP;
   localparam int RW = $clog2(ROWS);
   localparam int PW = (FREQDIV > 0) ? FREQDIV : 1;
   localparam int S  = (2**BPP) - 1;

   typedef enum logic {SCAN, BLANK} state_t;

   state_t            state_q, state_d;
   logic [PW-1:0]     presc_q, presc_d;
   logic [BPP-1:0]    slot_q, slot_d;
   logic [RW-1:0]     row_q, row_d;
   logic [N-1:0]      red_q, red_d;
   logic [N-1:0]      grn_q, grn_d;
   logic              ack_q, ack_d;
   logic              fs_q, fs_d;
   logic              blank_q, blank_d;
   logic [COLS-1:0]   rcol_q, rcol_d;
   logic [COLS-1:0]   gcol_q, gcol_d;
   logic              tick;
   logic              last_slot;
   logic              boundary;

   // Next-state and next-output computation for the scan FSM.
   always_comb begin
      state_d   = state_q;
      presc_d   = presc_q;
      slot_d    = slot_q;
      row_d     = row_q;
      red_d     = red_q;
      grn_d     = grn_q;
      ack_d     = 1'b0;
      fs_d      = 1'b0;
      blank_d   = 1'b0;
      rcol_d    = '0;
      gcol_d    = '0;
      tick      = EnableCount &&
                  ((FREQDIV == 0) || (presc_q == {PW{1'b1}}));
      last_slot = (slot_q == BPP'(S-1));
      boundary  = tick && (state_q == SCAN) && last_slot &&
                  (row_q == RW'(ROWS-1));
      if (EnableCount) begin
         presc_d = (FREQDIV == 0) ? '0 : presc_q + PW'(1);
      end
      if (tick) begin
         unique case (state_q)
            SCAN: begin
               if (last_slot) begin
                  slot_d = '0;
                  row_d  = (row_q == RW'(ROWS-1)) ? '0 : row_q + RW'(1);
`ifdef LED_SCAN_BLANK_EN
                  state_d = BLANK;
`endif
               end else begin
                  slot_d = slot_q + BPP'(1);
               end
            end
            BLANK: begin
               if (slot_q == BPP'(1)) begin
                  slot_d  = '0;
                  state_d = SCAN;
               end else begin
                  slot_d = slot_q + BPP'(1);
               end
            end
            default: state_d = SCAN;
         endcase
      end
      // A frame offer is only sampled at the boundary tick.
      if (boundary) begin
         fs_d = 1'b1;
         if (FrameValid) begin
            red_d = RedLevels;
            grn_d = GrnLevels;
            ack_d = 1'b1;
         end
      end
      // Columns use next-state data so a fresh capture shows immediately.
      if (state_d == BLANK) begin
         blank_d = 1'b1;
      end else begin
         for (int c = 0; c < COLS; c++) begin
            rcol_d[c] = red_d[(int'(row_d)*COLS + c)*BPP +: BPP] > slot_d;
            gcol_d[c] = grn_d[(int'(row_d)*COLS + c)*BPP +: BPP] > slot_d;
         end
      end
   end

   // State and registered outputs, synchronous active-high reset.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= SCAN;
         presc_q <= '0;
         slot_q  <= '0;
         row_q   <= '0;
         red_q   <= '0;
         grn_q   <= '0;
         ack_q   <= 1'b0;
         fs_q    <= 1'b0;
         blank_q <= 1'b0;
         rcol_q  <= '0;
         gcol_q  <= '0;
      end else begin
         state_q <= state_d;
         presc_q <= presc_d;
         slot_q  <= slot_d;
         row_q   <= row_d;
         red_q   <= red_d;
         grn_q   <= grn_d;
         ack_q   <= ack_d;
         fs_q    <= fs_d;
         blank_q <= blank_d;
         rcol_q  <= rcol_d;
         gcol_q  <= gcol_d;
      end
   end

   assign FrameAck   = ack_q;
   assign FrameStart = fs_q;
   assign RowSelect  = row_q;
   assign RedCols    = rcol_q;
   assign GrnCols    = gcol_q;
   assign Blank      = blank_q;

endmodule

// File: tb/tb_led_pwm_scanner.sv
// Directed bench for led_pwm_scanner, 4x4 matrix, BPP=2, FREQDIV=0.
// Scan position p counts enabled cycles as if the frame began at row 0.
module tb_led_pwm_scanner;

   localparam int ROWS = 4;
   localparam int COLS = 4;
   localparam int BPP  = 2;
`ifdef LED_SCAN_BLANK_EN
   localparam int OFF = 2;
`else
   localparam int OFF = 0;
`endif
   localparam int DW = 3 + OFF;
   localparam int FR = ROWS * DW;

   logic        CLK = 1'b0;
   logic        RST;
   logic        EnableCount;
   logic [63:0] RedLevels;
   logic [63:0] GrnLevels;
   logic        FrameValid;
   logic        FrameAck;
   logic        FrameStart;
   logic [1:0]  RowSelect;
   logic [3:0]  RedCols;
   logic [3:0]  GrnCols;
   logic        Blank;

   int tests = 0;
   int errors = 0;
   int p = 0;

   led_pwm_scanner #(
      .ROWS(ROWS), .COLS(COLS), .BPP(BPP), .FREQDIV(0)
   ) dut (
      .CLK(CLK), .RST(RST), .EnableCount(EnableCount),
      .RedLevels(RedLevels), .GrnLevels(GrnLevels),
      .FrameValid(FrameValid), .FrameAck(FrameAck),
      .FrameStart(FrameStart), .RowSelect(RowSelect),
      .RedCols(RedCols), .GrnCols(GrnCols), .Blank(Blank)
   );

   always #5 CLK = ~CLK;

   task automatic adv();
      @(posedge CLK);
      #1;
      if (RST) p = OFF;
      else if (EnableCount) p++;
   endtask

   task automatic adv_to(input int target);
      int guard;
      guard = 0;
      while (p < target && guard < 1000) begin
         adv();
         guard++;
      end
      tests++;
      if (p != target) begin
         errors++;
         $display("FAIL adv_to: position %0d required %0d", p, target);
      end
   endtask

   task automatic test_reset();
      RST = 1'b1; EnableCount = 1'b1; FrameValid = 1'b0;
      RedLevels = '0; GrnLevels = '0;
      adv(); adv();
      tests++;
      if ({RowSelect, RedCols, GrnCols, FrameAck, FrameStart, Blank}
          !== 13'd0) begin
         errors++;
         $display("FAIL reset_vals: got row=%0d r=%b g=%b a=%b s=%b b=%b",
                  RowSelect, RedCols, GrnCols, FrameAck, FrameStart, Blank);
      end
      RST = 1'b0;
      while (p < FR) begin
         adv();
         tests++;
         if (RowSelect !== 2'((p % FR) / DW) || RedCols !== 4'd0 ||
             GrnCols !== 4'd0 || FrameAck !== 1'b0 ||
             FrameStart !== ((p % FR) == 0) ||
             Blank !== ((p % DW) < OFF)) begin
            errors++;
            $display("FAIL reset_scan p=%0d: row=%0d r=%b g=%b a=%b s=%b b=%b",
                     p, RowSelect, RedCols, GrnCols, FrameAck, FrameStart,
                     Blank);
         end
      end
   endtask

   task automatic test_capture();
      logic [3:0] exp_r [3];
      exp_r[0] = 4'b0111; exp_r[1] = 4'b0101; exp_r[2] = 4'b0001;
      RST = 1'b1;
      adv();
      RedLevels = 64'h0227;
      GrnLevels = 64'h4000;
      FrameValid = 1'b1;
      RST = 1'b0;
      while (p < FR - 1) begin
         adv();
         tests++;
         if (FrameAck !== 1'b0) begin
            errors++;
            $display("FAIL early_ack p=%0d: ack=%b required 0", p, FrameAck);
         end
      end
      adv();
      tests++;
      if (FrameAck !== 1'b1 || FrameStart !== 1'b1 || RowSelect !== 2'd0) begin
         errors++;
         $display("FAIL capture_pulse: ack=%b start=%b row=%0d required 1 1 0",
                  FrameAck, FrameStart, RowSelect);
      end
      FrameValid = 1'b0;
      for (int s = 0; s < 3; s++) begin
         adv_to(FR + OFF + s);
         tests++;
         if (RedCols !== exp_r[s] || GrnCols !== 4'd0 || Blank !== 1'b0) begin
            errors++;
            $display("FAIL pwm_row0 slot%0d: r=%b g=%b b=%b required %b 0000 0",
                     s, RedCols, GrnCols, Blank, exp_r[s]);
         end
      end
      adv_to(FR + DW + OFF);
      tests++;
      if (RowSelect !== 2'd1 || RedCols !== 4'b0001 || GrnCols !== 4'b1000) begin
         errors++;
         $display("FAIL pwm_row1 slot0: row=%0d r=%b g=%b required 1 0001 1000",
                  RowSelect, RedCols, GrnCols);
      end
      adv();
      tests++;
      if (RedCols !== 4'b0001 || GrnCols !== 4'b0000) begin
         errors++;
         $display("FAIL pwm_row1 slot1: r=%b g=%b required 0001 0000",
                  RedCols, GrnCols);
      end
   endtask

   task automatic test_freeze();
      EnableCount = 1'b0;
      for (int i = 0; i < 5; i++) begin
         adv();
         tests++;
         if (RowSelect !== 2'd1 || RedCols !== 4'b0001 || GrnCols !== 4'd0 ||
             FrameAck !== 1'b0 || FrameStart !== 1'b0 || Blank !== 1'b0) begin
            errors++;
            $display("FAIL freeze%0d: row=%0d r=%b g=%b a=%b s=%b b=%b", i,
                     RowSelect, RedCols, GrnCols, FrameAck, FrameStart, Blank);
         end
      end
      EnableCount = 1'b1;
      adv();
      tests++;
      if (RowSelect !== 2'd1 || RedCols !== 4'd0 || GrnCols !== 4'd0) begin
         errors++;
         $display("FAIL freeze_resume: row=%0d r=%b g=%b required 1 0000 0000",
                  RowSelect, RedCols, GrnCols);
      end
      adv();
      tests++;
      if (RowSelect !== 2'd2) begin
         errors++;
         $display("FAIL freeze_next_row: row=%0d required 2", RowSelect);
      end
   endtask

   task automatic test_withdrawn();
      RedLevels = '1;
      FrameValid = 1'b1;
      adv_to(FR + 3*DW + OFF + 1);
      FrameValid = 1'b0;
      adv_to(2*FR);
      tests++;
      if (FrameAck !== 1'b0 || FrameStart !== 1'b1 || RowSelect !== 2'd0) begin
         errors++;
         $display("FAIL withdrawn_pulse: ack=%b start=%b row=%0d required 0 1 0",
                  FrameAck, FrameStart, RowSelect);
      end
      adv_to(2*FR + OFF);
      tests++;
      if (RedCols !== 4'b0111) begin
         errors++;
         $display("FAIL withdrawn_slot0: r=%b required 0111", RedCols);
      end
      adv();
      tests++;
      if (RedCols !== 4'b0101) begin
         errors++;
         $display("FAIL withdrawn_slot1: r=%b required 0101", RedCols);
      end
   endtask

   task automatic test_reset_mid();
      adv_to(2*FR + 2*DW);
      tests++;
      if (RowSelect !== 2'd2) begin
         errors++;
         $display("FAIL pre_reset_row: row=%0d required 2", RowSelect);
      end
      RST = 1'b1;
      adv();
      RST = 1'b0;
      tests++;
      if (RowSelect !== 2'd0 || RedCols !== 4'd0 || GrnCols !== 4'd0 ||
          FrameStart !== 1'b0 || Blank !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: row=%0d r=%b g=%b s=%b b=%b",
                  RowSelect, RedCols, GrnCols, FrameStart, Blank);
      end
      while (p < FR - 1) begin
         adv();
         tests++;
         if (RedCols !== 4'd0 || GrnCols !== 4'd0 || FrameAck !== 1'b0) begin
            errors++;
            $display("FAIL dark_after_reset p=%0d: r=%b g=%b a=%b",
                     p, RedCols, GrnCols, FrameAck);
         end
      end
   endtask

   task automatic test_back_to_back();
      RedLevels = '0;
      GrnLevels = '1;
      FrameValid = 1'b1;
      adv();
      tests++;
      if (FrameAck !== 1'b1 || FrameStart !== 1'b1) begin
         errors++;
         $display("FAIL b2b_ack1: ack=%b start=%b required 1 1",
                  FrameAck, FrameStart);
      end
      adv_to(FR + OFF + 2);
      tests++;
      if (GrnCols !== 4'b1111 || RedCols !== 4'd0) begin
         errors++;
         $display("FAIL b2b_full: g=%b r=%b required 1111 0000",
                  GrnCols, RedCols);
      end
      adv_to(2*FR);
      tests++;
      if (FrameAck !== 1'b1 || FrameStart !== 1'b1) begin
         errors++;
         $display("FAIL b2b_ack2: ack=%b start=%b required 1 1",
                  FrameAck, FrameStart);
      end
      adv();
      tests++;
      if (FrameAck !== 1'b0 || FrameStart !== 1'b0) begin
         errors++;
         $display("FAIL b2b_no_stretch: ack=%b start=%b required 0 0",
                  FrameAck, FrameStart);
      end
      FrameValid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_capture();
      test_freeze();
      test_withdrawn();
      test_reset_mid();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule

// File: doc/led_pwm_scanner.md
# led_pwm_scanner

Parametrised row-scanning driver for two-colour LED matrix boards, with multi-level PWM brightness per pixel. It sits between the game/render logic and the GPIO header. It holds a double-buffered frame: render logic offers a new frame with a valid/ack handshake, and the block swaps it in only at a frame boundary so the display never tears. It drives row select, per-colour column enables and a blanking flag.

## Interface
Parameters:
- ROWS, 16, number of matrix rows (≥2)
- COLS, 16, number of columns per row
- BPP, 2, brightness bits per pixel per colour (≥1); S = 2^BPP − 1 PWM slots per row
- FREQDIV, 0, slot length = 2^FREQDIV enabled cycles

Ports:
- CLK  in  1  clock
- RST  in  1  reset, synchronous, active-high
- EnableCount  in  1  advance scan; low freezes all counters and outputs
- RedLevels  in  ROWS*COLS*BPP  red level of pixel (r,c) at bits [(r*COLS+c)*BPP +: BPP]
- GrnLevels  in  ROWS*COLS*BPP  green levels, same packing
- FrameValid  in  1  new frame offered on RedLevels/GrnLevels; hold until FrameAck
- FrameAck  out  1  one-cycle pulse: frame captured into shadow buffer
- FrameStart  out  1  one-cycle pulse: first cycle of a new frame (RowSelect = 0)
- RowSelect  out  $clog2(ROWS)  active row
- RedCols  out  COLS  red column enables, bit c = column c
- GrnCols  out  COLS  green column enables
- Blank  out  1  blanking interval active; columns forced 0

## Operation
- State: prescaler (FREQDIV bits), slot 0..S−1, row 0..ROWS−1, scan FSM, shadow buffer (2·ROWS·COLS·BPP bits).
- Tick: an enabled cycle with prescaler = 2^FREQDIV−1. When FREQDIV = 0, every enabled cycle is a tick.
- FSM SCAN: the slot advances on each tick. On a tick with slot = S−1, the row advances, wrapping ROWS−1 → 0, and slot returns to 0.
- FSM BLANK: present only with the macro, see Configuration.
- PWM: pixel column bit = 1 iff shadow level > slot.
  - Level 0 is always off.
  - Level 2^BPP−1 is on for all slots.
  - Brightness is linear in level.
- Frame boundary: a tick with row = ROWS−1 and slot = S−1.
  - If FrameValid = 1 at the boundary, the shadow buffer loads both level vectors and FrameAck pulses.
  - If FrameValid = 0, the shadow buffer is retained and FrameAck stays 0.
  - FrameValid outside a boundary has no effect.
- Frame data is therefore constant for a whole frame. Input changes while FrameValid = 0 are ignored.
- Reset, at any time: counters 0, FSM SCAN, shadow buffer cleared (display dark until first capture). Any in-flight offer is dropped.

## Timing
- Every output is registered. Outputs are computed from next state, so they change on the same edge as the internal counters.
- Reset values: RowSelect = 0, RedCols = 0, GrnCols = 0, FrameAck = 0, FrameStart = 0, Blank = 0.
- Row dwell = S·2^FREQDIV enabled cycles; frame = ROWS·S·2^FREQDIV enabled cycles (no macro).
- FrameAck and FrameStart are high in the first cycle after a boundary, coincident with RowSelect = 0. Newly captured data is visible on the columns in that same cycle.
- With EnableCount = 0, all outputs hold. FrameAck and FrameStart clear after their single cycle and never stretch.
- FrameValid may drop the cycle after FrameAck. If FrameValid stays high, a further capture occurs at every boundary.

## Configuration
- LED_SCAN_BLANK_EN defined:
  - Each row advance, including the wrap to row 0, enters BLANK for 2 ticks.
  - During BLANK, RowSelect already shows the new row, Blank = 1 and columns are 0.
  - SCAN then resumes at slot 0.
  - Row dwell = (S+2)·2^FREQDIV enabled cycles. FrameStart and FrameAck pulse on the first BLANK cycle of row 0.
- Not defined: no BLANK state, Blank tied to 0.

## Test plan
Parameters for all scenarios: ROWS=4, COLS=4, BPP=2, FREQDIV=0, so S=3 and a frame is 12 cycles.
- Reset: hold RST for 2 cycles → RowSelect=0, RedCols=GrnCols=0, FrameAck=FrameStart=Blank=0; rows cycle 0,1,2,3 every 3 cycles, all dark.
- Capture + PWM: set red levels (0,0)=3, (0,1)=1, (0,2)=2 and hold FrameValid → FrameAck and FrameStart pulse together exactly 12 cycles after RST release; RedCols over row-0 slots = 0b0111, 0b0101, 0b0001; GrnCols=0.
- Freeze: drop EnableCount for 5 cycles mid-row 1 → all outputs constant; the remaining dwell completes after re-enable with no slot lost.
- Late/withdrawn offer: raise FrameValid at row 2 and drop it at row 3 slot 1 → no FrameAck; the old frame is displayed unchanged.
- Reset mid-frame: assert RST at row 2 → next cycle RowSelect=0 with columns 0; the display stays dark until the next capture.
- With LED_SCAN_BLANK_EN: row period = 5 cycles; Blank=1 with columns 0 for the first 2 cycles of each row; frame = 20 cycles.
